// File: rtl/redstone_output_monitor.sv
// -----------------------------------------------------------------------------
// redstone_output_monitor
//
// Watches the output vector of a compiled redstone circuit. A fixed number of
// clock cycles after each tick, it samples the outputs and compares them with
// the previous sample. When the outputs have changed, it writes an event into
// a first-word-fall-through FIFO. Each event holds the tick count as a
// timestamp and the new output value. The host drains the FIFO over a
// valid/ready handshake, so it receives only the transitions and not a record
// of every tick.
//
// Ports:
//   i_clk           system clock (the tick pulse is derived from this clock)
//   i_rst_n         asynchronous active-low reset
//   i_tick          single-cycle pulse, one per redstone tick
//   i_outputs       monitored output vector [NUM_OUTPUTS-1:0]
//   i_enable        1 = detected changes generate events
//   o_evt_valid     an event is present at the FIFO head
//   o_evt_data      {timestamp[TS_W-1:0], outputs[NUM_OUTPUTS-1:0]}
//   i_evt_ready     host accepts the head event
//   o_fifo_level    number of occupied FIFO entries
//   o_overflow      sticky flag: at least one event was dropped
//   i_clr_overflow  clears o_overflow (a drop in the same cycle takes priority)
//   o_tick_count    number of ticks since reset, wraps
// -----------------------------------------------------------------------------
module redstone_output_monitor #(
  parameter int NUM_OUTPUTS  = 2,
  parameter int TS_W         = 16,
  parameter int DEPTH        = 8,   // power of two, >= 2
  parameter int SAMPLE_DELAY = 2    // >= 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tick,
  input  logic [NUM_OUTPUTS-1:0]        i_outputs,
  input  logic                          i_enable,
  output logic                          o_evt_valid,
  output logic [TS_W+NUM_OUTPUTS-1:0]   o_evt_data,
  input  logic                          i_evt_ready,
  output logic [$clog2(DEPTH):0]        o_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_clr_overflow,
  output logic [TS_W-1:0]               o_tick_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(SAMPLE_DELAY + 1);
  localparam int EW = TS_W + NUM_OUTPUTS;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [DW-1:0] DLY_LOAD   = DW'(SAMPLE_DELAY);
  localparam logic [DW-1:0] DLY_LAST   = DW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TS_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]          dly_q, dly_d;        // 0 = idle, else cycles to sample
  logic [TS_W-1:0]        ts_q, ts_d;          // timestamp of the pending sample
  logic [NUM_OUTPUTS-1:0] snap_q, snap_d;
  logic                   first_q, first_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;

  logic [EW-1:0]          mem [DEPTH];

  logic fire, changed, push, pop, full, push_ok, drop, valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    dly_d      = dly_q;
    ts_d       = ts_q;
    snap_d     = snap_q;
    first_d    = first_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;

    // The sample point is the last cycle of the delay window. A tick that
    // arrives in that same cycle abandons the sample and starts a new window.
    fire    = (dly_q == DLY_LAST) && !i_tick;
    changed = first_q || (i_outputs != snap_q);
    push    = fire && i_enable && changed;

    valid   = (level_q != '0);
    pop     = valid && i_evt_ready;
    full    = (level_q == FULL_LEVEL);
    // When the FIFO is full, a pop in the same cycle frees a slot for the push.
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    if (i_tick) begin
      tick_cnt_d = tick_cnt_q + TS_W'(1);
      dly_d      = DLY_LOAD;
      ts_d       = tick_cnt_q + TS_W'(1);
    end else if (dly_q != '0) begin
      dly_d = dly_q - DW'(1);
    end

    if (fire) begin
      // The snapshot follows the outputs even when no event is generated.
      // While i_enable=0, this keeps the baseline current without reporting it.
      snap_d = i_outputs;
      if (push) first_d = 1'b0;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear takes priority, so that event loss
    // is always reported.
    if (drop)                ovf_d = 1'b1;
    else if (i_clr_overflow) ovf_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_q <= '0;
      dly_q      <= '0;
      ts_q       <= '0;
      snap_q     <= '0;
      first_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      dly_q      <= dly_d;
      ts_q       <= ts_d;
      snap_q     <= snap_d;
      first_q    <= first_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: the storage array is not reset. Reset clears the pointers and the
  // level, so stale contents are never visible, and the output is forced to
  // zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_q] <= {ts_q, i_outputs};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_evt_valid  = valid;
  assign o_evt_data   = valid ? mem[rd_ptr_q] : '0;
  assign o_fifo_level = level_q;
  assign o_overflow   = ovf_q;
  assign o_tick_count = tick_cnt_q;

endmodule

// File: doc/redstone_output_monitor.md
Name: redstone_output_monitor

Overview:
- Sits directly downstream of a compiled redstone circuit and consumes its output vector in the system clock domain.
- Samples the outputs a fixed settle delay after each tick and compares them against the previous snapshot.
- On any change, timestamps the new value with the tick count and buffers it in a FIFO.
- The host drains events over a valid/ready interface, so it sees only output transitions, not every tick.

Parameters:
- NUM_OUTPUTS, 2, width of the monitored output vector.
- TS_W, 16, width of the tick counter and of the event timestamp.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- SAMPLE_DELAY, 2, i_clk cycles from the tick pulse to the sample point; must be at least 1.

Ports:
- i_clk  in  1  system clock; the same clock from which the tick pulse is derived.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  single-cycle pulse, coincident with each redstone tick edge.
- i_outputs  in  NUM_OUTPUTS  output vector of the redstone circuit.
- i_enable  in  1  when 1, detected changes generate events.
- o_evt_valid  out  1  event available at the FIFO head.
- o_evt_data  out  TS_W+NUM_OUTPUTS  event word, {timestamp, output value}; the timestamp is in the MSBs.
- i_evt_ready  in  1  host accepts the head event.
- o_fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- o_overflow  out  1  sticky flag: at least one event was dropped.
- i_clr_overflow  in  1  clears o_overflow.
- o_tick_count  out  TS_W  number of ticks since reset.

Behaviour:
- Reset (asynchronous, i_rst_n=0) sets all state to zero:
  - o_evt_valid=0, o_fifo_level=0, o_overflow=0, o_tick_count=0.
  - o_evt_data=0, the snapshot is 0, and the sample-delay counter is idle.
  - The first-sample flag is set to 1.
  - Reset mid-operation discards all queued and pending events.
- Tick counter:
  - Increments on every i_tick and wraps from 2^TS_W-1 to 0.
  - The first tick after reset yields count 1.
- Sample timing:
  - i_tick loads the delay counter with SAMPLE_DELAY and latches the post-increment tick count as the pending timestamp.
  - The counter decrements once per cycle.
  - i_outputs is sampled in the cycle the counter reaches 0, i.e. SAMPLE_DELAY cycles after the i_tick cycle.
- i_tick while a sample is pending: the pending sample is abandoned, and the delay and timestamp restart from the new tick. No event is generated for the abandoned tick.
- Compare at the sample point:
  - Event condition is i_enable=1 AND (first-sample flag=1 OR sampled value != snapshot).
  - The snapshot is always updated to the sampled value, whether or not an event is generated or accepted.
  - The first-sample flag clears only when an event is generated, so the baseline value is always reported.
  - While i_enable=0, the snapshot tracks the outputs silently.
- FIFO behaviour:
  - First-word-fall-through; a pushed event appears on o_evt_data with o_evt_valid=1 in the next cycle when the FIFO was empty.
  - Pop occurs when o_evt_valid=1 and i_evt_ready=1.
  - o_evt_data holds stable while valid and not accepted.
  - Pointers wrap modulo DEPTH.
  - o_fifo_level updates in the cycle after the push or pop. A simultaneous push and pop leaves the level unchanged.
- Full FIFO:
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the event and sets o_overflow in the next cycle.
- Overflow flag: i_clr_overflow clears o_overflow. If a drop coincides with a clear, set wins.
- Empty FIFO: o_evt_valid=0, and i_evt_ready is ignored.
- Latency from tick to visible event (empty FIFO): SAMPLE_DELAY+1 cycles.

Test Plan:
- Baseline: reset, i_enable=1, i_outputs=2'b01, pulse i_tick at cycle 10 → o_evt_valid rises at cycle 13 with o_evt_data={16'd1,2'b01}; o_tick_count=1.
- No-change suppression: hold 2'b01 for 5 more ticks → no new events; o_tick_count=6. Change to 2'b10 before tick 7 → single event {16'd7,2'b10}.
- Back-to-back ticks: pulse i_tick on two consecutive cycles → only one sample, timestamped with the second tick. No event if the value is unchanged.
- Overflow: i_evt_ready=0, DEPTH=8, 10 alternating-value ticks.
  - o_fifo_level saturates at 8 and o_overflow=1.
  - Draining returns the first 8 events in order.
  - i_clr_overflow clears the flag; a same-cycle drop keeps it set.
- Full with simultaneous pop: FIFO at 8 and a push coincides with an accepted pop → level stays 8, no overflow, the new event lands at the tail.
- Async reset mid-drain (i_rst_n low between clock edges) → o_evt_valid=0, level 0, o_tick_count=0 immediately. The next enabled sample re-emits a baseline event.
